dino_game_ctrl: RTL
===================

// Module: dino_game_ctrl
// PURPOSE
//  Frame-rate game-state engine for the dino runner; sits directly upstream of the VGA pixel compositor.
//  Advances once per frame_tick: IDLE/RUN/DEAD FSM, jump trajectory, obstacle scroll, difficulty speed, BCD score/high score.
//  Compositor consumes dino_h/obst_x/obst_sel/game_state for drawing; returns per-frame collide flag; score feeds 7-seg driver.
// PARAMETERS
//  SCREEN_W   640  visible width, px
//  OBST_W     39   obstacle sprite width, px
//  JUMP_MAX   180  apex height of dino above ground, px
//  JUMP_STEP  10   height change per tick, px
//  V0         9    base scroll speed, px/tick
//  V1         18   max scroll speed (mode=1), px/tick
//  SPEED_DIV  256  ticks between speed increments (mode=1)
//  SCORE_DIV  32   ticks per score increment
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst         in   1   asynchronous, active-high reset
//  frame_tick  in   1   1-cycle pulse, one per game step
//  start_btn   in   1   debounced start level; rising edge acts
//  jump_btn    in   1   debounced jump level, active-high; rising edge acts
//  mode        in   1   0 = fixed speed, +1 score; 1 = ramping speed, +2 score
//  collide     in   1   sticky dino/obstacle overlap from compositor, valid at frame_tick
//  game_state  out  2   00 IDLE, 01 RUN, 10 DEAD
//  dino_h      out  10  dino height above ground, px
//  obst_x      out  11  obstacle right-edge x, px
//  obst_sel    out  2   obstacle pattern index 0..3
//  speed       out  5   current scroll speed, px/tick
//  score       out  16  4-digit BCD current score
//  hi_score    out  16  4-digit BCD best score
// BEHAVIOUR
//  Reset (async): IDLE, dino_h=0, obst_x=SCREEN_W+OBST_W, obst_sel=0, speed=V0, score=0, hi_score=0, LFSR=8'hA5, jump FSM GROUND.
//  Edge detect: start/jump registered every clk; rising edges latched as pending until next frame_tick, then cleared.
//  All state updates occur only on frame_tick cycles; outputs change 1 clk after that tick.
//  FSM: IDLE -start-> RUN (score=0, dino_h=0, obst_x=SCREEN_W+OBST_W, speed=V0).
//       RUN -collide-> DEAD (same tick: freeze all motion; hi_score=max(hi_score,score)).
//       DEAD -start-> IDLE. Start in RUN ignored. Collide outside RUN ignored.
//  Jump sub-FSM (RUN only): GROUND -jump-> UP; UP: dino_h+=JUMP_STEP, at >=JUMP_MAX clamp to JUMP_MAX, go DOWN;
//       DOWN: dino_h-=JUMP_STEP, at <=JUMP_STEP set 0, go GROUND. Jump while UP/DOWN ignored (no double jump).
//  Obstacle: obst_x-=speed per tick; if obst_x<speed (no underflow) -> wrap to SCREEN_W+OBST_W, obst_sel=LFSR[1:0], LFSR steps (x^8+x^6+x^5+x^4+1).
//  Speed: mode=0 -> speed=V0 every tick. mode=1 -> +1 every SPEED_DIV ticks, saturate V1. Mode toggle mid-run takes effect next tick.
//  Score: tick counter wraps at SCORE_DIV; on wrap score+=1 (mode0) or +2 (mode1), BCD with carry; saturate 9999 (no wrap).
//  Simultaneous collide and score wrap on same tick: collide wins, score not incremented, hi_score uses pre-tick score.
//  rst asserted mid-jump/mid-run: immediate return to reset values incl. hi_score.
// STRUCTURE
//  dino_defs.vh: state encodings (ST_IDLE/RUN/DEAD), jump-state encodings, SCREEN_W/OBST_W defaults, LFSR seed.
//  Sub-module bcd_add4: combinational 4-digit BCD + {1,2} with saturation at 9999; instantiated once for score.
//  Main body: edge latches, game FSM, jump FSM, scroll/LFSR, speed and score counters in separate always blocks.
// TESTING
//  Reset then start pulse + 1 tick -> game_state=01, obst_x=679, speed=9, score=0000.
//  RUN, jump edge, 18 ticks -> dino_h=180; 18 more ticks -> dino_h=0; second jump at tick 5 ignored.
//  RUN mode=0, obst_x=5 speed=9 on tick -> obst_x=679, obst_sel=LFSR[1:0], no underflow.
//  mode=1, 2304 ticks -> speed saturates at 18; score +2 per 32 ticks, 0998->1000 BCD carry; 9998 +2 -> 9999.
//  score=0123, hi=0100, collide at tick -> DEAD, hi_score=0123, obst_x/dino_h frozen; start -> IDLE; next start clears score.
//  rst pulse mid-jump (dino_h=90) -> all outputs to reset values in same clk, no frame_tick needed.

Source files
------------

// File: rtl/dino_game_ctrl_pkg.sv
// Shared constants, state encodings and the obstacle-pattern LFSR step for the dino game engine.
package dino_game_ctrl_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned OBST_W    = 39;
  localparam int unsigned JUMP_MAX  = 180;
  localparam int unsigned JUMP_STEP = 10;
  localparam int unsigned V0        = 9;
  localparam int unsigned V1        = 18;
  localparam int unsigned SPEED_DIV = 256;
  localparam int unsigned SCORE_DIV = 32;

  localparam logic [10:0] OBST_START = 11'(SCREEN_W + OBST_W);
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDead = 2'b10
  } game_st_e;

  typedef enum logic [1:0] {
    JmpGround = 2'b00,
    JmpUp     = 2'b01,
    JmpDown   = 2'b10
  } jump_st_e;

  // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Game-engine <-> compositor/controls bundle; slave is the engine side.
interface dino_game_ctrl_if;
  logic        frame_tick;
  logic        start_btn;
  logic        jump_btn;
  logic        mode;
  logic        collide;
  logic [1:0]  game_state;
  logic [9:0]  dino_h;
  logic [10:0] obst_x;
  logic [1:0]  obst_sel;
  logic [4:0]  speed;
  logic [15:0] score;
  logic [15:0] hi_score;

  modport master (
    output frame_tick, start_btn, jump_btn, mode, collide,
    input  game_state, dino_h, obst_x, obst_sel, speed, score, hi_score
  );

  modport slave (
    input  frame_tick, start_btn, jump_btn, mode, collide,
    output game_state, dino_h, obst_x, obst_sel, speed, score, hi_score
  );
endinterface

// File: rtl/dino_game_ctrl_bcd_add4.sv
// Combinational 4-digit BCD increment by 1 or 2, saturating at 9999.
module dino_game_ctrl_bcd_add4 (
  input  logic [15:0] a,
  input  logic        inc2,
  output logic [15:0] sum
);

  always_comb begin
    logic [4:0] c;
    logic [4:0] d;
    sum = '0;
    c   = inc2 ? 5'd2 : 5'd1;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + c;
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 5'd1;
      end else begin
        c = 5'd0;
      end
      sum[i*4 +: 4] = d[3:0];
    end
    if (c != 5'd0) sum = 16'h9999;
  end

endmodule

// File: rtl/dino_game_ctrl.sv
// Frame-rate game-state engine: game FSM, jump FSM, obstacle scroll, speed ramp and BCD score.
module dino_game_ctrl
  import dino_game_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  dino_game_ctrl_if.slave  bus
);

  localparam int unsigned SPD_W = $clog2(SPEED_DIV);
  localparam int unsigned SC_W  = $clog2(SCORE_DIV);
  localparam logic [9:0]  H_STEP = 10'(JUMP_STEP);
  localparam logic [9:0]  H_MAX  = 10'(JUMP_MAX);
  localparam logic [4:0]  SPD_LO = 5'(V0);
  localparam logic [4:0]  SPD_HI = 5'(V1);

  logic tick;
  logic start_q, jump_q, start_pend_q, jump_pend_q;
  logic start_evt, jump_evt;
  logic run_init, move, die;

  game_st_e          state_q, state_d;
  jump_st_e          jst_q, jst_d;
  logic [9:0]        dino_h_q, dino_h_d;
  logic [10:0]       obst_x_q, obst_x_d;
  logic [1:0]        obst_sel_q, obst_sel_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [SPD_W-1:0]  spd_cnt_q, spd_cnt_d;
  logic [4:0]        speed_q, speed_d;
  logic [SC_W-1:0]   sc_cnt_q, sc_cnt_d;
  logic [15:0]       score_q, score_d, score_inc;
  logic [15:0]       hi_q, hi_d;

  assign tick = bus.frame_tick;

  // A rising edge on the tick cycle itself is honoured, then the pending flag clears.
  assign start_evt = start_pend_q | (bus.start_btn & ~start_q);
  assign jump_evt  = jump_pend_q  | (bus.jump_btn  & ~jump_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q      <= 1'b0;
      jump_q       <= 1'b0;
      start_pend_q <= 1'b0;
      jump_pend_q  <= 1'b0;
    end else begin
      start_q      <= bus.start_btn;
      jump_q       <= bus.jump_btn;
      start_pend_q <= tick ? 1'b0 : start_evt;
      jump_pend_q  <= tick ? 1'b0 : jump_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        StIdle:  if (start_evt)   state_d = StRun;
        StRun:   if (bus.collide) state_d = StDead;
        StDead:  if (start_evt)   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    run_init = tick && (state_q == StIdle) && start_evt;
    move     = tick && (state_q == StRun) && !bus.collide;
    die      = tick && (state_q == StRun) && bus.collide;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jst_q    <= JmpGround;
      dino_h_q <= '0;
    end else begin
      jst_q    <= jst_d;
      dino_h_q <= dino_h_d;
    end
  end

  // The jump tick already counts as the first climb step.
  always_comb begin
    jst_d    = jst_q;
    dino_h_d = dino_h_q;
    if (run_init) begin
      jst_d    = JmpGround;
      dino_h_d = '0;
    end else if (move) begin
      unique case (jst_q)
        JmpGround: begin
          if (jump_evt) begin
            jst_d    = JmpUp;
            dino_h_d = H_STEP;
          end
        end
        JmpUp: begin
          if (dino_h_q + H_STEP >= H_MAX) begin
            jst_d    = JmpDown;
            dino_h_d = H_MAX;
          end else begin
            dino_h_d = dino_h_q + H_STEP;
          end
        end
        JmpDown: begin
          if (dino_h_q <= H_STEP) begin
            jst_d    = JmpGround;
            dino_h_d = '0;
          end else begin
            dino_h_d = dino_h_q - H_STEP;
          end
        end
        default: begin
          jst_d    = JmpGround;
          dino_h_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obst_x_q   <= OBST_START;
      obst_sel_q <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      obst_x_q   <= obst_x_d;
      obst_sel_q <= obst_sel_d;
      lfsr_q     <= lfsr_d;
    end
  end

  always_comb begin
    obst_x_d   = obst_x_q;
    obst_sel_d = obst_sel_q;
    lfsr_d     = lfsr_q;
    if (run_init) begin
      obst_x_d = OBST_START;
    end else if (move) begin
      if (obst_x_q < {6'b0, speed_q}) begin
        obst_x_d   = OBST_START;
        obst_sel_d = lfsr_q[1:0];
        lfsr_d     = lfsr_next(lfsr_q);
      end else begin
        obst_x_d = obst_x_q - {6'b0, speed_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_cnt_q <= '0;
      speed_q   <= SPD_LO;
    end else begin
      spd_cnt_q <= spd_cnt_d;
      speed_q   <= speed_d;
    end
  end

  always_comb begin
    spd_cnt_d = spd_cnt_q;
    speed_d   = speed_q;
    if (run_init) begin
      spd_cnt_d = '0;
      speed_d   = SPD_LO;
    end else if (move) begin
      spd_cnt_d = (spd_cnt_q == SPD_W'(SPEED_DIV - 1)) ? '0 : spd_cnt_q + SPD_W'(1);
      if (!bus.mode) begin
        speed_d = SPD_LO;
      end else if ((spd_cnt_q == SPD_W'(SPEED_DIV - 1)) && (speed_q < SPD_HI)) begin
        speed_d = speed_q + 5'd1;
      end
    end
  end

  dino_game_ctrl_bcd_add4 u_bcd_add4 (
    .a    (score_q),
    .inc2 (bus.mode),
    .sum  (score_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_cnt_q <= '0;
      score_q  <= '0;
      hi_q     <= '0;
    end else begin
      sc_cnt_q <= sc_cnt_d;
      score_q  <= score_d;
      hi_q     <= hi_d;
    end
  end

  // Collide wins over a coinciding score step since move is low on a death tick.
  always_comb begin
    sc_cnt_d = sc_cnt_q;
    score_d  = score_q;
    hi_d     = hi_q;
    if (run_init) begin
      sc_cnt_d = '0;
      score_d  = '0;
    end else if (move) begin
      if (sc_cnt_q == SC_W'(SCORE_DIV - 1)) begin
        sc_cnt_d = '0;
        score_d  = score_inc;
      end else begin
        sc_cnt_d = sc_cnt_q + SC_W'(1);
      end
    end
    if (die && (score_q > hi_q)) hi_d = score_q;
  end

  assign bus.game_state = state_q;
  assign bus.dino_h     = dino_h_q;
  assign bus.obst_x     = obst_x_q;
  assign bus.obst_sel   = obst_sel_q;
  assign bus.speed      = speed_q;
  assign bus.score      = score_q;
  assign bus.hi_score   = hi_q;

endmodule
